spike_event_logger: RTL
=======================

Name: spike_event_logger

Overview:
- Downstream stage of the LIF/LSNN neuron core.
- Consumes the neuron's single-cycle spike pulse and timestamps each spike against a free-running cycle counter.
- Buffers events in a small FIFO and streams them out as 2-byte records over a valid/ready byte interface.
- Gives host or readout logic exact spike timing, without the 7-bit spike count aliasing seen on the bidirectional pins.

Parameters:
- TS_WIDTH, 12, timestamp counter width; legal range 8..14.
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..16.
- DROP_WIDTH, 8, width of the saturating dropped-event counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- spike_in  input  1  spike pulse from the neuron core (its registered spike output)
- en  input  1  logging enable; when low, the timestamp counter holds and no events are captured
- ts_clear  input  1  synchronous clear of the timestamp counter
- rd_data  output  8  current record byte
- rd_valid  output  1  rd_data is valid
- rd_ready  input  1  consumer accepts rd_data this cycle
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of stored events
- drop_count  output  DROP_WIDTH  events lost to FIFO full; saturates at all-ones
- overflow  output  1  sticky flag; set on any drop, cleared only by reset

Behaviour:
- Reset (async, rst_n=0):
  - ts counter, FIFO pointers, fifo_level, drop_count, overflow, byte phase, pending-lost flag and spike_prev all go to 0.
  - rd_valid=0, rd_data=0.
- Timestamp counter:
  - If ts_clear=1, it loads 0 at the edge (ts_clear has priority over en).
  - Otherwise, if en=1, it increments by 1 per cycle and wraps from 2^TS_WIDTH-1 to 0.
  - Otherwise it holds.
- Event detection:
  - event = en & spike_in & ~spike_prev, where spike_prev is spike_in registered every cycle regardless of en.
  - spike_in held high for N cycles produces exactly one event.
  - Captured timestamp = ts counter value in the cycle the event is seen, i.e. the pre-increment value.
- FIFO write:
  - On an event edge the entry {lost, ts} is written.
  - The write is accepted if the FIFO is not full, or if a pop occurs in the same cycle (simultaneous push+pop at full is accepted and fifo_level stays at FIFO_DEPTH).
  - lost = the pending-lost flag, which is cleared by the accepted write.
- FIFO full with no pop:
  - The event is dropped.
  - drop_count increments, saturating.
  - overflow <= 1; pending-lost <= 1.
- Record format, 2 bytes, byte0 first:
  - byte0 = {1'b1, lost, ts[TS_WIDTH-1:8] zero-extended to 6 bits}.
  - byte1 = ts[7:0].
  - Bit 7 of byte0 is a sync marker.
- Readout:
  - rd_valid = (fifo_level != 0).
  - rd_data is combinational from the head entry and the phase bit.
  - rd_data is stable while rd_valid=1 and rd_ready=0.
  - On the rd_valid&rd_ready edge: if phase=0, phase<=1; if phase=1, phase<=0 and the head is popped.
  - rd_ready while rd_valid=0 has no effect.
- Latency: an event seen in cycle k is written at edge k; rd_valid=1 from cycle k+1 when the FIFO was empty.
- Pointer wrap: read/write pointers are modulo FIFO_DEPTH, with full/empty derived from fifo_level.
- en deasserted mid-readout: draining continues; only capture and counting stop.
- Reset mid-record: the partially read record is discarded.

Optional Feature:
- Macro: SPIKE_LOGGER_ISI_EN.
- Defined:
  - The ts field carries the inter-spike interval instead of the absolute time.
  - The interval is the count of en=1 cycles since the previous event (including dropped events), saturating at 2^TS_WIDTH-1.
  - The interval counter is reset to 0 by each event, by ts_clear, and by reset.
  - The first event after reset or ts_clear reports the cycles since that point.
- Undefined: absolute wrapping timestamps exactly as above; no interval logic is synthesized.

Test Plan:
1. Reset, then idle 20 cycles with en=1 -> rd_valid=0, fifo_level=0, drop_count=0, overflow=0.
2. Pulse ts_clear, then 1-cycle spikes at ts=5 and ts=0x123, rd_ready=1 -> bytes 0x80, 0x05, 0x81, 0x23; fifo_level ends at 0.
3. spike_in held high 4 cycles starting at ts=10 -> exactly one record 0x80, 0x0A.
4. rd_ready=0, 11 separated spikes -> fifo_level=8, drop_count=3, overflow=1; drain 1 record, spike at ts=0x200 -> last record byte0=0xC2, byte1=0x00; overflow stays 1.
5. rd_ready=0 with a record pending for 5 cycles -> rd_data constant 0x80; assert rd_ready for one cycle -> rd_data becomes byte1, FIFO not yet popped.
6. With SPIKE_LOGGER_ISI_EN: spikes at ts=3, 10, 4200 -> ISI fields 3, 7, 4095 (saturated).

Source files
------------

// File: rtl/spike_event_logger.sv
// rtl/spike_event_logger.sv - spike timestamp logger with event FIFO and 2-byte record readout
// Optional feature macro: SPIKE_LOGGER_ISI_EN (ts field carries the inter-spike interval)
module spike_event_logger #(
  parameter int TS_WIDTH   = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        spike_in,
  input  logic                        en,
  input  logic                        ts_clear,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [DROP_WIDTH-1:0]       drop_count,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = TS_WIDTH + 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] cap_ts;
  logic                spike_prev;
  logic                phase_q;
  logic                pend_lost_q;
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [EW-1:0]       head;
  logic [13:0]         head_ext;
  logic                evt, full, hs, pop, push, drop;

  // Rising edge of the spike pulse while logging is enabled.
  assign evt  = en & spike_in & ~spike_prev;
  assign full = (fifo_level == FULL_LVL);
  assign rd_valid = (fifo_level != '0);
  assign hs   = rd_valid & rd_ready;
  assign pop  = hs & phase_q;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign push = evt & (~full | pop);
  assign drop = evt & full & ~pop;

  // Free-running timestamp counter; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ts_q <= '0;
    else if (ts_clear) ts_q <= '0;
    else if (en)       ts_q <= ts_q + 1'b1;
  end

  // Previous spike level, tracked regardless of en so a held spike is one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spike_prev <= 1'b0;
    else        spike_prev <= spike_in;
  end

`ifdef SPIKE_LOGGER_ISI_EN
  logic [TS_WIDTH-1:0] isi_q;

  // Interval counter: the event cycle itself is the first en cycle of the next interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    isi_q <= '0;
    else if (ts_clear)             isi_q <= '0;
    else if (evt)                  isi_q <= TS_WIDTH'(1);
    else if (en && (isi_q != '1))  isi_q <= isi_q + 1'b1;
  end

  assign cap_ts = isi_q;
`else
  assign cap_ts = ts_q;
`endif

  // Event storage; contents are only observed through the level-qualified head.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pend_lost_q, cap_ts};
  end

  // Pointers, occupancy, byte phase and loss bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      phase_q     <= 1'b0;
      pend_lost_q <= 1'b0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (hs) phase_q <= ~phase_q;
      if (push)      pend_lost_q <= 1'b0;
      else if (drop) pend_lost_q <= 1'b1;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  assign head     = mem[rd_ptr];
  assign head_ext = 14'(head[TS_WIDTH-1:0]);

  // Record byte mux: sync-marked header byte first, then the low timestamp byte.
  always_comb begin
    rd_data = '0;
    if (rd_valid) begin
      if (phase_q) rd_data = head_ext[7:0];
      else         rd_data = {1'b1, head[TS_WIDTH], head_ext[13:8]};
    end
  end

endmodule
